// File: rtl/udma_sdio_pkg.sv
// Shared types and constants for the SDIO transaction sequencer.
package udma_sdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CMD       = 3'd1,
    S_CMD_WAIT  = 3'd2,
    S_DATA      = 3'd3,
    S_DATA_WAIT = 3'd4,
    S_DONE      = 3'd5
  } sdio_state_e;

  localparam int unsigned STAT_CMD_TO  = 0;
  localparam int unsigned STAT_CMD_CRC = 1;
  localparam int unsigned STAT_WDG     = 2;
  localparam int unsigned STAT_DAT_CRC = 3;
  localparam int unsigned STAT_ERR_W   = 4;
  localparam int unsigned STAT_BLK_W   = 8;

  localparam logic [1:0] CMD_ERR_NONE    = 2'b00;
  localparam logic [1:0] CMD_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] CMD_ERR_CRC     = 2'b10;

endpackage

// File: rtl/udma_sdio_wdg.sv
// Data-phase watchdog: clearable up-counter that flags when the next count reaches a nonzero limit.
module udma_sdio_wdg
  import udma_sdio_pkg::*;
#(
  parameter int unsigned WDG_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WDG_W-1:0] limit_i,
  output logic             hit_c_o
);

  logic [WDG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WDG_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare against the incremented value so the limit counts whole waiting cycles.
  assign hit_c_o = en_i && (limit_i != '0) && (cnt_d == limit_i);

endmodule

// File: rtl/udma_sdio_txrx_ctrl.sv
// SDIO transaction sequencer: command, response wait, then N data blocks; reports EOT and status.
module udma_sdio_txrx_ctrl
  import udma_sdio_pkg::*;
#(
  parameter int unsigned WDG_W      = 24,
  parameter int unsigned BLK_SIZE_W = 10,
  parameter int unsigned BLK_NUM_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_start_i,
  input  logic [5:0]            cfg_cmd_op_i,
  input  logic [31:0]           cfg_cmd_arg_i,
  input  logic [2:0]            cfg_cmd_rsp_type_i,
  input  logic                  cfg_data_en_i,
  input  logic                  cfg_data_rwn_i,
  input  logic                  cfg_data_quad_i,
  input  logic [BLK_SIZE_W-1:0] cfg_data_block_size_i,
  input  logic [BLK_NUM_W-1:0]  cfg_data_block_num_i,
  input  logic [WDG_W-1:0]      cfg_timeout_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [5:0]            cmd_op_o,
  output logic [31:0]           cmd_arg_o,
  output logic [2:0]            cmd_rsp_type_o,
  input  logic                  cmd_done_i,
  input  logic [1:0]            cmd_err_i,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  data_rwn_o,
  output logic                  data_quad_o,
  output logic [BLK_SIZE_W-1:0] data_block_size_o,
  input  logic                  data_done_i,
  input  logic                  data_crc_err_i,
  output logic                  data_abort_o,
  output logic                  busy_o,
  output logic                  eot_o,
  output logic [15:0]           status_o
);

  sdio_state_e state_q, state_d;

  logic                  cmd_valid_q, cmd_valid_d;
  logic                  data_valid_q, data_valid_d;
  logic                  busy_q, busy_d;
  logic                  eot_q, eot_d;
  logic                  abort_q, abort_d;

  logic [5:0]            cmd_op_q;
  logic [31:0]           cmd_arg_q;
  logic [2:0]            rsp_type_q;
  logic                  data_en_q, rwn_q, quad_q;
  logic [BLK_SIZE_W-1:0] blk_size_q;
  logic [BLK_NUM_W-1:0]  blk_num_q, blk_cnt_q;
  logic [WDG_W-1:0]      timeout_q;

  logic [STAT_BLK_W-1:0] done_cnt_q;
  logic [STAT_ERR_W-1:0] err_q;
  logic                  ovr_q;

  logic accept_c, blk_ok_c, blk_crc_c, blk_last_c, cmd_rsp_c;
  logic wdg_clr_c, wdg_en_c, wdg_hit_c;

  udma_sdio_wdg #(
    .WDG_W (WDG_W)
  ) u_wdg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (wdg_clr_c),
    .en_i    (wdg_en_c),
    .limit_i (timeout_q),
    .hit_c_o (wdg_hit_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (cfg_start_i) state_d = S_CMD;
      S_CMD:       if (cmd_ready_i) state_d = S_CMD_WAIT;
      S_CMD_WAIT: begin
        if (cmd_done_i) begin
          if (cmd_err_i != CMD_ERR_NONE || !data_en_q) state_d = S_DONE;
          else                                         state_d = S_DATA;
        end
      end
      S_DATA:      if (data_ready_i) state_d = S_DATA_WAIT;
      S_DATA_WAIT: begin
        // A completion in the same cycle as the watchdog limit takes priority.
        if (data_done_i) begin
          if (data_crc_err_i || blk_last_c) state_d = S_DONE;
          else                              state_d = S_DATA;
        end else if (wdg_hit_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept_c     = 1'b0;
    cmd_rsp_c    = 1'b0;
    blk_ok_c     = 1'b0;
    blk_crc_c    = 1'b0;
    blk_last_c   = 1'b0;
    abort_d      = 1'b0;
    wdg_clr_c    = 1'b0;
    wdg_en_c     = 1'b0;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    busy_d       = 1'b0;
    eot_d        = 1'b0;

    accept_c     = (state_q == S_IDLE) && cfg_start_i;
    cmd_rsp_c    = (state_q == S_CMD_WAIT) && cmd_done_i;
    blk_ok_c     = (state_q == S_DATA_WAIT) && data_done_i && !data_crc_err_i;
    blk_crc_c    = (state_q == S_DATA_WAIT) && data_done_i && data_crc_err_i;
    blk_last_c   = (blk_cnt_q == blk_num_q);
    abort_d      = (state_q == S_DATA_WAIT) && !data_done_i && wdg_hit_c;
    wdg_clr_c    = (state_q == S_DATA);
    wdg_en_c     = (state_q == S_DATA_WAIT);
    cmd_valid_d  = (state_d == S_CMD);
    data_valid_d = (state_d == S_DATA);
    busy_d       = (state_d != S_IDLE);
    eot_d        = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      eot_q        <= 1'b0;
      abort_q      <= 1'b0;
      cmd_op_q     <= '0;
      cmd_arg_q    <= '0;
      rsp_type_q   <= '0;
      data_en_q    <= 1'b0;
      rwn_q        <= 1'b0;
      quad_q       <= 1'b0;
      blk_size_q   <= '0;
      blk_num_q    <= '0;
      timeout_q    <= '0;
      blk_cnt_q    <= '0;
      done_cnt_q   <= '0;
      err_q        <= '0;
      ovr_q        <= 1'b0;
    end else begin
      cmd_valid_q  <= cmd_valid_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      eot_q        <= eot_d;
      abort_q      <= abort_d;

      if (accept_c) begin
        cmd_op_q   <= cfg_cmd_op_i;
        cmd_arg_q  <= cfg_cmd_arg_i;
        rsp_type_q <= cfg_cmd_rsp_type_i;
        data_en_q  <= cfg_data_en_i;
        rwn_q      <= cfg_data_rwn_i;
        quad_q     <= cfg_data_quad_i;
        blk_size_q <= cfg_data_block_size_i;
        blk_num_q  <= cfg_data_block_num_i;
        timeout_q  <= cfg_timeout_i;
        done_cnt_q <= '0;
        err_q      <= '0;
        ovr_q      <= 1'b0;
      end else if (cfg_start_i) begin
        ovr_q <= 1'b1;
      end

      if (cmd_rsp_c) begin
        err_q[STAT_CMD_CRC:STAT_CMD_TO] <= cmd_err_i;
        blk_cnt_q                       <= '0;
      end

      if (blk_ok_c) begin
        blk_cnt_q <= blk_cnt_q + BLK_NUM_W'(1);
        if (done_cnt_q != {STAT_BLK_W{1'b1}}) begin
          done_cnt_q <= done_cnt_q + STAT_BLK_W'(1);
        end
      end

      if (blk_crc_c) err_q[STAT_DAT_CRC] <= 1'b1;
      if (abort_d)   err_q[STAT_WDG]     <= 1'b1;
    end
  end

  assign cmd_valid_o       = cmd_valid_q;
  assign data_valid_o      = data_valid_q;
  assign busy_o            = busy_q;
  assign eot_o             = eot_q;
  assign data_abort_o      = abort_q;
  assign cmd_op_o          = cmd_op_q;
  assign cmd_arg_o         = cmd_arg_q;
  assign cmd_rsp_type_o    = rsp_type_q;
  assign data_rwn_o        = rwn_q;
  assign data_quad_o       = quad_q;
  assign data_block_size_o = blk_size_q;
  assign status_o          = {done_cnt_q, 2'b00, ovr_q, |err_q, err_q};

endmodule

// File: tb/tb_udma_sdio_txrx_ctrl.sv
// Directed self-checking bench for udma_sdio_txrx_ctrl with a simple data-engine responder.
module tb_udma_sdio_txrx_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_start_i;
  logic [5:0]  cfg_cmd_op_i;
  logic [31:0] cfg_cmd_arg_i;
  logic [2:0]  cfg_cmd_rsp_type_i;
  logic        cfg_data_en_i, cfg_data_rwn_i, cfg_data_quad_i;
  logic [9:0]  cfg_data_block_size_i;
  logic [7:0]  cfg_data_block_num_i;
  logic [23:0] cfg_timeout_i;
  logic        cmd_valid_o, cmd_ready_i;
  logic [5:0]  cmd_op_o;
  logic [31:0] cmd_arg_o;
  logic [2:0]  cmd_rsp_type_o;
  logic        cmd_done_i;
  logic [1:0]  cmd_err_i;
  logic        data_valid_o, data_ready_i, data_rwn_o, data_quad_o;
  logic [9:0]  data_block_size_o;
  logic        data_done_i, data_crc_err_i, data_abort_o;
  logic        busy_o, eot_o;
  logic [15:0] status_o;

  int nchk = 0;
  int nerr = 0;
  logic [9:0] bsz_seen;
  int  n, hs, aborts, alat;
  bit  seen_eot;

  always #5 clk_i = ~clk_i;

  udma_sdio_txrx_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_start_i(cfg_start_i),
    .cfg_cmd_op_i(cfg_cmd_op_i), .cfg_cmd_arg_i(cfg_cmd_arg_i),
    .cfg_cmd_rsp_type_i(cfg_cmd_rsp_type_i), .cfg_data_en_i(cfg_data_en_i),
    .cfg_data_rwn_i(cfg_data_rwn_i), .cfg_data_quad_i(cfg_data_quad_i),
    .cfg_data_block_size_i(cfg_data_block_size_i), .cfg_data_block_num_i(cfg_data_block_num_i),
    .cfg_timeout_i(cfg_timeout_i), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_op_o(cmd_op_o), .cmd_arg_o(cmd_arg_o), .cmd_rsp_type_o(cmd_rsp_type_o),
    .cmd_done_i(cmd_done_i), .cmd_err_i(cmd_err_i), .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i), .data_rwn_o(data_rwn_o), .data_quad_o(data_quad_o),
    .data_block_size_o(data_block_size_o), .data_done_i(data_done_i),
    .data_crc_err_i(data_crc_err_i), .data_abort_o(data_abort_o), .busy_o(busy_o),
    .eot_o(eot_o), .status_o(status_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input logic [5:0] op, input logic [31:0] arg, input logic den,
                           input logic [9:0] bsz, input logic [7:0] bnum, input logic [23:0] tmo);
    cfg_cmd_op_i          = op;
    cfg_cmd_arg_i         = arg;
    cfg_cmd_rsp_type_i    = 3'd1;
    cfg_data_en_i         = den;
    cfg_data_rwn_i        = 1'b1;
    cfg_data_quad_i       = 1'b1;
    cfg_data_block_size_i = bsz;
    cfg_data_block_num_i  = bnum;
    cfg_timeout_i         = tmo;
    cfg_start_i           = 1'b1;
    tick();
    cfg_start_i           = 1'b0;
  endtask

  // Runs until eot_o or budget; data engine accepts at once and completes 3 cycles later.
  task automatic run_txn(input int budget, input int crc_blk, input bit done_en,
                         output int nc, output bit eot_seen, output int nhs,
                         output int nab, output int ab_lat);
    int wait_cnt = -1;
    int blk = 0;
    int hs_n = 0;
    nc = 1; eot_seen = 0; nhs = 0; nab = 0; ab_lat = -1;
    while (!eot_seen && nc <= budget) begin
      if (eot_o) begin
        eot_seen = 1;
      end else begin
        if (data_abort_o) begin
          nab++;
          ab_lat = nc - (hs_n + 1);
        end
        data_done_i = 1'b0; data_crc_err_i = 1'b0; data_ready_i = 1'b0;
        if (wait_cnt == 0) begin
          data_done_i    = 1'b1;
          data_crc_err_i = (blk == crc_blk);
          blk++;
          wait_cnt = -1;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end
        if (data_valid_o) begin
          data_ready_i = 1'b1;
          nhs++;
          hs_n = nc;
          bsz_seen = data_block_size_o;
          if (done_en) wait_cnt = 3;
        end
        tick();
        nc++;
      end
    end
    data_ready_i = 1'b0; data_done_i = 1'b0; data_crc_err_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; cfg_start_i = 1'b0; cfg_cmd_op_i = '0; cfg_cmd_arg_i = '0;
    cfg_cmd_rsp_type_i = '0; cfg_data_en_i = 0; cfg_data_rwn_i = 0; cfg_data_quad_i = 0;
    cfg_data_block_size_i = '0; cfg_data_block_num_i = '0; cfg_timeout_i = '0;
    cmd_ready_i = 0; cmd_done_i = 0; cmd_err_i = '0; data_ready_i = 0;
    data_done_i = 0; data_crc_err_i = 0; bsz_seen = '0;
    tick(); tick();
    check("rst_busy", busy_o, 0);
    check("rst_eot", eot_o, 0);
    check("rst_status", status_o, 0);
    check("rst_valids", {cmd_valid_o, data_valid_o, data_abort_o}, 0);
    rst_i = 1'b0;
    tick();

    // No-data command, immediate ready/done
    cmd_ready_i = 1; cmd_done_i = 1; cmd_err_i = 2'b00;
    start_txn(6'd8, 32'h1AA, 1'b0, 10'd0, 8'd0, 24'd0);
    check("t1_cmd_valid", cmd_valid_o, 1);
    check("t1_cmd_op", cmd_op_o, 8);
    check("t1_cmd_arg", cmd_arg_o, 32'h1AA);
    check("t1_busy", busy_o, 1);
    run_txn(50, -1, 1, n, seen_eot, hs, aborts, alat);
    check("t1_eot_seen", seen_eot, 1);
    check("t1_eot_latency", n, 4);
    check("t1_status", status_o, 16'h0000);
    check("t1_busy_drop", busy_o, 0);

    // Start in the IDLE cycle that carries eot_o is accepted
    start_txn(6'd2, 32'h0, 1'b0, 10'd0, 8'd0, 24'd0);
    check("t1b_eot_single", eot_o, 0);
    check("t1b_cmd_valid", cmd_valid_o, 1);
    check("t1b_cmd_op", cmd_op_o, 2);
    run_txn(50, -1, 1, n, seen_eot, hs, aborts, alat);
    check("t1b_eot_latency", n, 4);
    tick();

    // Command timeout with data enabled
    cmd_err_i = 2'b01;
    start_txn(6'd17, 32'h55, 1'b1, 10'd511, 8'd2, 24'd0);
    run_txn(50, -1, 1, n, seen_eot, hs, aborts, alat);
    check("t2_eot_seen", seen_eot, 1);
    check("t2_no_data", hs, 0);
    check("t2_status", status_o, 16'h0011);
    tick();
    check("t2_eot_single", eot_o, 0);
    cmd_err_i = 2'b00;

    // 3-block read; cfg changes after start must not matter
    start_txn(6'd18, 32'h1000, 1'b1, 10'd511, 8'd2, 24'd0);
    cfg_data_block_size_i = 10'd5; cfg_data_block_num_i = 8'd0;
    run_txn(200, -1, 1, n, seen_eot, hs, aborts, alat);
    check("t3_eot_seen", seen_eot, 1);
    check("t3_handshakes", hs, 3);
    check("t3_block_size", bsz_seen, 511);
    check("t3_status", status_o, 16'h0300);
    check("t3_rwn_quad", {data_rwn_o, data_quad_o}, 2'b11);
    tick();

    // CRC error on the 2nd of 4 blocks
    start_txn(6'd18, 32'h2000, 1'b1, 10'd63, 8'd3, 24'd0);
    run_txn(200, 1, 1, n, seen_eot, hs, aborts, alat);
    check("t4_eot_seen", seen_eot, 1);
    check("t4_handshakes", hs, 2);
    check("t4_status", status_o, 16'h0118);
    tick();

    // Done on the same cycle the watchdog limit is reached: done wins
    start_txn(6'd17, 32'h0, 1'b1, 10'd3, 8'd0, 24'd4);
    run_txn(100, -1, 1, n, seen_eot, hs, aborts, alat);
    check("t5_eot_seen", seen_eot, 1);
    check("t5_no_abort", aborts, 0);
    check("t5_status", status_o, 16'h0100);
    tick();

    // Watchdog expiry at 100 cycles
    start_txn(6'd17, 32'h0, 1'b1, 10'd3, 8'd0, 24'd100);
    run_txn(400, -1, 0, n, seen_eot, hs, aborts, alat);
    check("t6_eot_seen", seen_eot, 1);
    check("t6_abort_count", aborts, 1);
    check("t6_abort_latency", alat, 100);
    check("t6_status", status_o, 16'h0014);
    tick();
    check("t6_abort_low", data_abort_o, 0);

    // Overrun while waiting for cmd_ready; sticky until the next accepted start
    cmd_ready_i = 0; cmd_done_i = 0;
    start_txn(6'd13, 32'hCAFE, 1'b0, 10'd0, 8'd0, 24'd0);
    cfg_cmd_op_i = 6'h3F;
    tick(); tick();
    check("t7_valid_held", cmd_valid_o, 1);
    check("t7_op_held", cmd_op_o, 13);
    cfg_start_i = 1'b1; tick(); cfg_start_i = 1'b0;
    check("t7_ovr_set", status_o, 16'h0020);
    cmd_ready_i = 1; cmd_done_i = 1;
    run_txn(50, -1, 1, n, seen_eot, hs, aborts, alat);
    check("t7_eot_seen", seen_eot, 1);
    check("t7_status", status_o, 16'h0020);
    tick();
    start_txn(6'd1, 32'h0, 1'b0, 10'd0, 8'd0, 24'd0);
    run_txn(50, -1, 1, n, seen_eot, hs, aborts, alat);
    check("t7_ovr_cleared", status_o, 16'h0000);
    tick();

    // Disabled watchdog hangs in DATA_WAIT; overrun then reset
    start_txn(6'd17, 32'h0, 1'b1, 10'd7, 8'd0, 24'd0);
    run_txn(10000, -1, 0, n, seen_eot, hs, aborts, alat);
    check("t8_no_eot", seen_eot, 0);
    check("t8_no_abort", aborts, 0);
    check("t8_busy", busy_o, 1);
    cfg_start_i = 1'b1; tick(); cfg_start_i = 1'b0;
    check("t8_ovr", status_o[5], 1);
    check("t8_still_busy", busy_o, 1);
    rst_i = 1'b1; tick();
    check("t8_rst_outs", {cmd_valid_o, data_valid_o, data_abort_o, busy_o, eot_o}, 0);
    check("t8_rst_status", status_o, 0);
    check("t8_rst_latches", {cmd_op_o, cmd_arg_o, data_block_size_o}, 0);
    rst_i = 1'b0; tick();
    check("t8_no_eot_after", {eot_o, data_abort_o}, 0);
    start_txn(6'd8, 32'h1AA, 1'b0, 10'd0, 8'd0, 24'd0);
    run_txn(50, -1, 1, n, seen_eot, hs, aborts, alat);
    check("t8_new_eot", seen_eot, 1);
    check("t8_new_status", status_o, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
